// File: rtl/evr_rx_decoder.sv
// EVG link receive decoder: comma alignment FSM, event strobes, distributed bus, heartbeat watchdog.
// Define EVR_TOD_EN to build the time-of-day seconds decoder; otherwise its outputs are tied to 0.
module evr_rx_decoder #(
    parameter int unsigned RXCLK_NOMINAL_FREQUENCY = 125000000,
    parameter int unsigned DISTRIBUTED_BUS_WIDTH   = 8,
    parameter int unsigned TOD_SECONDS_WIDTH       = 32,
    parameter int unsigned COMMA_LOCK_COUNT        = 4,
    parameter int unsigned COMMA_TIMEOUT           = 1024,
    parameter int unsigned HEARTBEAT_TIMEOUT       = RXCLK_NOMINAL_FREQUENCY * 2
) (
    input  logic                                 evrRxClk,
    input  logic                                 evrRxReset,
    input  logic [15:0]                          evrRxData,
    input  logic [1:0]                           evrRxCharIsK,
    output logic                                 evrLinkUp,
    output logic                                 evrEventStrobe,
    output logic [7:0]                           evrEventCode,
    output logic [DISTRIBUTED_BUS_WIDTH-1:0]     evrDistributedBus,
    output logic                                 evrHeartbeat,
    output logic                                 evrPing,
    output logic [31:0]                          evrHeartbeatInterval,
    output logic                                 evrHeartbeatTimeout,
    output logic [15:0]                          evrLinkErrorCount,
    output logic [TOD_SECONDS_WIDTH-1:0]         evrSeconds,
    output logic                                 evrSecondsStrobe,
    output logic                                 evrTodError
);

    localparam int unsigned TIMER_W = $clog2(COMMA_TIMEOUT + 1);
    localparam int unsigned GOOD_W  = $clog2(COMMA_LOCK_COUNT + 1);
    localparam int unsigned BC_W    = $clog2(TOD_SECONDS_WIDTH + 2);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_next_c;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_next_c;
    logic [GOOD_W-1:0]   good_q;
    logic [GOOD_W-1:0]   good_next_c;

    logic                is_comma_c;
    logic                is_bad_c;
    logic                active_c;
    logic                drop_c;
    logic                event_c;
    logic                hb_c;
    logic                ping_c;

    logic                hb_prev_q;
    logic                ping_prev_q;
    logic [31:0]         hb_cnt_q;

    assign is_comma_c = (evrRxCharIsK == 2'b01) && (evrRxData[7:0] == 8'hBC);
    assign is_bad_c   = evrRxCharIsK[1] || (evrRxCharIsK[0] && (evrRxData[7:0] != 8'hBC));

    // Alignment state register
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) begin
            state_q <= HUNT;
            timer_q <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_next_c;
            timer_q <= timer_next_c;
            good_q  <= good_next_c;
        end
    end

    // Next-state: comma counting and gap watchdog; a comma always rescues the gap timer
    always_comb begin
        state_next_c = state_q;
        timer_next_c = timer_q;
        good_next_c  = good_q;
        case (state_q)
            HUNT: begin
                if (is_comma_c) begin
                    state_next_c = CHECK;
                    good_next_c  = GOOD_W'(1);
                    timer_next_c = '0;
                end
            end
            CHECK: begin
                if (is_comma_c) begin
                    good_next_c  = good_q + GOOD_W'(1);
                    timer_next_c = '0;
                    if (good_q + GOOD_W'(1) == GOOD_W'(COMMA_LOCK_COUNT)) begin
                        state_next_c = LOCKED;
                    end
                end else if (is_bad_c || timer_q == TIMER_W'(COMMA_TIMEOUT)) begin
                    state_next_c = HUNT;
                end else begin
                    timer_next_c = timer_q + TIMER_W'(1);
                end
            end
            LOCKED: begin
                if (is_comma_c) begin
                    timer_next_c = '0;
                end else if (is_bad_c || timer_q == TIMER_W'(COMMA_TIMEOUT)) begin
                    state_next_c = HUNT;
                end else begin
                    timer_next_c = timer_q + TIMER_W'(1);
                end
            end
            default: state_next_c = HUNT;
        endcase
    end

    // Output decode: a word is only delivered when the link is locked before and after it
    always_comb begin
        active_c = (state_q == LOCKED) && (state_next_c == LOCKED);
        drop_c   = (state_q == LOCKED) && (state_next_c != LOCKED);
        event_c  = active_c && !evrRxCharIsK[0] && (evrRxData[7:0] != 8'h00);
        hb_c     = active_c && evrRxData[8] && !hb_prev_q;
        ping_c   = active_c && evrRxData[9] && !ping_prev_q;
    end

    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) begin
            evrLinkUp            <= 1'b0;
            evrEventStrobe       <= 1'b0;
            evrEventCode         <= '0;
            evrDistributedBus    <= '0;
            evrHeartbeat         <= 1'b0;
            evrPing              <= 1'b0;
            evrLinkErrorCount    <= '0;
            hb_prev_q            <= 1'b0;
            ping_prev_q          <= 1'b0;
        end else begin
            evrLinkUp         <= (state_next_c == LOCKED);
            evrEventStrobe    <= event_c;
            evrHeartbeat      <= hb_c;
            evrPing           <= ping_c;
            evrDistributedBus <= active_c ? evrRxData[8 +: DISTRIBUTED_BUS_WIDTH] : '0;
            hb_prev_q         <= active_c && evrRxData[8];
            ping_prev_q       <= active_c && evrRxData[9];
            if (event_c) begin
                evrEventCode <= evrRxData[7:0];
            end
            if (drop_c && evrLinkErrorCount != 16'hFFFF) begin
                evrLinkErrorCount <= evrLinkErrorCount + 16'd1;
            end
        end
    end

    // Heartbeat interval counter and watchdog; a heartbeat wins over a same-cycle timeout
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) begin
            hb_cnt_q             <= '0;
            evrHeartbeatInterval <= '0;
            evrHeartbeatTimeout  <= 1'b0;
        end else if (hb_c) begin
            evrHeartbeatInterval <= (hb_cnt_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : hb_cnt_q + 32'd1;
            hb_cnt_q             <= '0;
            evrHeartbeatTimeout  <= 1'b0;
        end else begin
            if (hb_cnt_q != 32'hFFFF_FFFF) begin
                hb_cnt_q <= hb_cnt_q + 32'd1;
            end
            if (hb_cnt_q == 32'(HEARTBEAT_TIMEOUT - 1)) begin
                evrHeartbeatTimeout <= 1'b1;
            end
        end
    end

`ifdef EVR_TOD_EN
    logic [TOD_SECONDS_WIDTH-1:0] tod_shift_q;
    logic [BC_W-1:0]              tod_bits_q;

    // Seconds are shifted in MSB first by events 0x70/0x71 and committed by 0x7D
    always_ff @(posedge evrRxClk) begin
        if (evrRxReset) begin
            tod_shift_q      <= '0;
            tod_bits_q       <= '0;
            evrSeconds       <= '0;
            evrSecondsStrobe <= 1'b0;
            evrTodError      <= 1'b0;
        end else begin
            evrSecondsStrobe <= 1'b0;
            if (!active_c) begin
                tod_shift_q <= '0;
                tod_bits_q  <= '0;
            end else if (event_c) begin
                if (evrRxData[7:0] == 8'h70 || evrRxData[7:0] == 8'h71) begin
                    tod_shift_q <= {tod_shift_q[TOD_SECONDS_WIDTH-2:0], evrRxData[0]};
                    if (tod_bits_q != BC_W'(TOD_SECONDS_WIDTH + 1)) begin
                        tod_bits_q <= tod_bits_q + BC_W'(1);
                    end
                end else if (evrRxData[7:0] == 8'h7D) begin
                    if (tod_bits_q == BC_W'(TOD_SECONDS_WIDTH)) begin
                        evrSeconds       <= tod_shift_q;
                        evrSecondsStrobe <= 1'b1;
                    end else begin
                        evrTodError <= 1'b1;
                    end
                    tod_shift_q <= '0;
                    tod_bits_q  <= '0;
                end
            end
        end
    end
`else
    assign evrSeconds       = '0;
    assign evrSecondsStrobe = 1'b0;
    assign evrTodError      = 1'b0;
`endif

endmodule

// File: tb/tb_evr_rx_decoder.sv
// Randomized bench for evr_rx_decoder against a cycle-indexed behavioural model.
// Follows EVR_TOD_EN the same way the design does.
module tb_evr_rx_decoder;

    localparam int unsigned HB_TO = 1500;
    localparam int unsigned CT    = 1024;
    localparam int unsigned LOCK  = 4;
    localparam int unsigned TSW   = 32;
    localparam int unsigned DBW   = 8;
`ifdef EVR_TOD_EN
    localparam bit TOD = 1'b1;
`else
    localparam bit TOD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   rx_data = '0;
    logic [1:0]    rx_k = '0;
    logic          link_up;
    logic          ev_strobe;
    logic [7:0]    ev_code;
    logic [DBW-1:0] dbus;
    logic          hb;
    logic          ping;
    logic [31:0]   hb_interval;
    logic          hb_timeout;
    logic [15:0]   link_err;
    logic [TSW-1:0] seconds;
    logic          sec_strobe;
    logic          tod_err;

    always #5 clk = ~clk;

    evr_rx_decoder #(
        .RXCLK_NOMINAL_FREQUENCY(125000000),
        .DISTRIBUTED_BUS_WIDTH(DBW),
        .TOD_SECONDS_WIDTH(TSW),
        .COMMA_LOCK_COUNT(LOCK),
        .COMMA_TIMEOUT(CT),
        .HEARTBEAT_TIMEOUT(HB_TO)
    ) dut (
        .evrRxClk(clk),
        .evrRxReset(rst),
        .evrRxData(rx_data),
        .evrRxCharIsK(rx_k),
        .evrLinkUp(link_up),
        .evrEventStrobe(ev_strobe),
        .evrEventCode(ev_code),
        .evrDistributedBus(dbus),
        .evrHeartbeat(hb),
        .evrPing(ping),
        .evrHeartbeatInterval(hb_interval),
        .evrHeartbeatTimeout(hb_timeout),
        .evrLinkErrorCount(link_err),
        .evrSeconds(seconds),
        .evrSecondsStrobe(sec_strobe),
        .evrTodError(tod_err)
    );

    int total = 0;
    int bad   = 0;

    // Model: link status as comma count + gap, heartbeat timing from edge indices
    longint  e = 0;
    longint  anchor = 0;
    int      m_commas = 0;
    int      m_gap = 0;
    bit      m_locked = 0;
    bit      m_hb_prev = 0;
    bit      m_ping_prev = 0;
    int      m_err = 0;
    bit      tod_q[$];

    logic        exp_link, exp_strobe, exp_hb, exp_ping, exp_timeout, exp_sec_strobe, exp_tod_err;
    logic [7:0]  exp_code, exp_dbus;
    logic [31:0] exp_interval, exp_sec;
    logic [15:0] exp_err;

    bit hb_en = 0;
    int word_idx = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_apply(input logic [15:0] d, input logic [1:0] k, input logic r);
        bit comma, badw, was, stay, ev;
        logic [31:0] v;
        e++;
        if (r) begin
            m_commas = 0; m_gap = 0; m_locked = 0; m_hb_prev = 0; m_ping_prev = 0; m_err = 0;
            anchor = e; tod_q.delete();
            exp_link = 0; exp_strobe = 0; exp_code = 0; exp_dbus = 0; exp_hb = 0; exp_ping = 0;
            exp_interval = 0; exp_timeout = 0; exp_err = 0; exp_sec = 0; exp_sec_strobe = 0; exp_tod_err = 0;
            return;
        end
        comma = (k == 2'b01) && (d[7:0] == 8'hBC);
        badw  = k[1] || (k[0] && d[7:0] != 8'hBC);
        was   = m_locked;
        if (m_commas == 0) begin
            if (comma) begin m_commas = 1; m_gap = 0; end
        end else if (comma) begin
            m_gap = 0;
            if (!m_locked) begin
                m_commas++;
                if (m_commas == LOCK) m_locked = 1;
            end
        end else if (badw || m_gap == CT) begin
            if (m_locked && m_err < 65535) m_err++;
            m_locked = 0;
            m_commas = 0;
        end else begin
            m_gap++;
        end
        stay = was && m_locked;
        ev   = stay && !k[0] && d[7:0] != 8'h00;
        exp_link   = m_locked;
        exp_err    = 16'(m_err);
        exp_strobe = ev;
        if (ev) exp_code = d[7:0];
        exp_dbus = stay ? d[15:8] : 8'h00;
        exp_hb   = stay && d[8] && !m_hb_prev;
        exp_ping = stay && d[9] && !m_ping_prev;
        m_hb_prev   = stay && d[8];
        m_ping_prev = stay && d[9];
        if (exp_hb) begin
            exp_interval = (e - anchor > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(e - anchor);
            anchor = e;
        end
        exp_timeout = (e - anchor) >= HB_TO;
        exp_sec_strobe = 0;
        if (TOD) begin
            if (!stay) tod_q.delete();
            else if (ev) begin
                if (d[7:0] == 8'h70 || d[7:0] == 8'h71) tod_q.push_back(d[0]);
                else if (d[7:0] == 8'h7D) begin
                    if (tod_q.size() == TSW) begin
                        v = 0;
                        foreach (tod_q[i]) v = {v[30:0], tod_q[i]};
                        exp_sec = v;
                        exp_sec_strobe = 1;
                    end else begin
                        exp_tod_err = 1;
                    end
                    tod_q.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("link_up", link_up, exp_link);
        check_eq("event_strobe", ev_strobe, exp_strobe);
        check_eq("event_code", ev_code, exp_code);
        check_eq("dbus", dbus, exp_dbus);
        check_eq("heartbeat", hb, exp_hb);
        check_eq("ping", ping, exp_ping);
        check_eq("hb_interval", hb_interval, exp_interval);
        check_eq("hb_timeout", hb_timeout, exp_timeout);
        check_eq("link_err", link_err, exp_err);
        check_eq("seconds", seconds, exp_sec);
        check_eq("sec_strobe", sec_strobe, exp_sec_strobe);
        check_eq("tod_err", tod_err, exp_tod_err);
    endtask

    task automatic step(input logic [15:0] d, input logic [1:0] k, input logic r);
        rx_data = d;
        rx_k    = k;
        rst     = r;
        word_idx++;
        model_apply(d, k, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] rand_dbus();
        logic [7:0] b;
        b    = 8'($urandom());
        b[1] = ($urandom_range(0, 15) == 0);
        b[0] = hb_en && (word_idx % 1000 == 0);
        return b;
    endfunction

    function automatic logic [7:0] rand_code();
        if ($urandom_range(0, 9) == 0) return 8'h00;
        return 8'($urandom_range(1, 8'h6F));
    endfunction

    task automatic send_comma();
        step({rand_dbus(), 8'hBC}, 2'b01, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] code);
        step({rand_dbus(), code}, 2'b00, 1'b0);
    endtask

    task automatic locked_words(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 29) == 0) send_comma();
            else send_data(rand_code());
        end
    endtask

    task automatic send_tod(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            if ($urandom_range(0, 7) == 0) send_comma();
            send_data(val[i] ? 8'h71 : 8'h70);
        end
        send_data(8'h7D);
    endtask

    initial begin
        int r;
        repeat (3) step(16'h0000, 2'b00, 1'b1);
        check_eq("reset_link", link_up, 1'b0);

        // Three commas then a bad word never lock
        for (int i = 0; i < 3; i++) begin
            send_comma();
            repeat (99) send_data(rand_code());
        end
        check_eq("three_commas_no_lock", link_up, 1'b0);
        step(16'h0000, 2'b10, 1'b0);

        // Four commas 100 apart lock
        for (int i = 0; i < 4; i++) begin
            send_comma();
            if (i < 3) begin
                repeat (99) send_data(rand_code());
                check_eq("pre_lock", link_up, 1'b0);
            end
        end
        check_eq("lock_after_4", link_up, 1'b1);

        // Event word with heartbeat bit, then repeated bit0 gives no second pulse
        step({8'h05, 8'h2A}, 2'b00, 1'b0);
        check_eq("ev2_strobe", ev_strobe, 1'b1);
        check_eq("ev2_code", ev_code, 8'h2A);
        check_eq("ev2_dbus", dbus, 8'h05);
        check_eq("ev2_hb", hb, 1'b1);
        step({8'h05, 8'h2B}, 2'b00, 1'b0);
        check_eq("ev2_hb_once", hb, 1'b0);

        // Heartbeats every 1000 words with TOD frames interleaved
        hb_en = 1;
        locked_words(1500);
        send_tod(32'h1234_5678, 32);
        check_eq("tod_strobe", sec_strobe, TOD);
        check_eq("tod_seconds", seconds, TOD ? 32'h1234_5678 : 32'h0);
        locked_words(1000);
        send_tod(32'h0BAD_F00D, 31);
        check_eq("tod_short_err", tod_err, TOD);
        check_eq("tod_short_keep", seconds, TOD ? 32'h1234_5678 : 32'h0);
        locked_words(1200);
        check_eq("hb_interval_1000", hb_interval, 32'd1000);

        // Heartbeat starvation then recovery
        hb_en = 0;
        locked_words(1600);
        check_eq("hb_timeout_set", hb_timeout, 1'b1);
        step({8'h01, 8'h11}, 2'b00, 1'b0);
        check_eq("hb_recover_pulse", hb, 1'b1);
        check_eq("hb_timeout_clear", hb_timeout, 1'b0);

        // Bad word drop
        step(16'h0000, 2'b10, 1'b0);
        check_eq("drop_bad_link", link_up, 1'b0);
        check_eq("drop_bad_err", link_err, 16'd1);
        check_eq("drop_bad_dbus", dbus, 8'h00);

        // Comma starvation drop at the gap boundary
        repeat (4) send_comma();
        check_eq("relock", link_up, 1'b1);
        repeat (CT) send_data(rand_code());
        check_eq("gap_edge_still_up", link_up, 1'b1);
        send_data(rand_code());
        check_eq("gap_drop_link", link_up, 1'b0);
        check_eq("gap_drop_err", link_err, 16'd2);

        // Null code and commas while locked, then mid-stream reset
        repeat (4) send_comma();
        step({8'h00, 8'h00}, 2'b00, 1'b0);
        check_eq("null_code_no_strobe", ev_strobe, 1'b0);
        send_comma();
        check_eq("comma_no_strobe", ev_strobe, 1'b0);
        hb_en = 1;
        locked_words(50);
        step({8'h03, 8'h44}, 2'b00, 1'b1);
        check_eq("rst_link", link_up, 1'b0);
        check_eq("rst_err", link_err, 16'd0);
        check_eq("rst_interval", hb_interval, 32'd0);
        step(16'h0000, 2'b00, 1'b0);

        // Unconstrained random traffic
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 199);
            if ($urandom_range(0, 1999) == 0) step({rand_dbus(), 8'($urandom())}, 2'($urandom()), 1'b1);
            else if (r < 10) send_comma();
            else if (r == 10) step({rand_dbus(), 8'($urandom())}, 2'b10 | 2'($urandom_range(0, 1)), 1'b0);
            else if (r == 11) step({rand_dbus(), 8'h3C}, 2'b01, 1'b0);
            else if (r < 40) send_data(8'h70 + 8'($urandom_range(0, 1)));
            else if (r < 43) send_data(8'h7D);
            else send_data(8'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
